instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Inverse of the RV32I instruction decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit RV32I word.
- Writes each encoded word sequentially into instruction memory through a registered write port.
- Used by the test infrastructure and boot path to load programs that the fetch/decode stages later execute.
- A start command sets the base address and instruction count. A done pulse signals completion.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width; the address wraps modulo 2^ADDR_W.
- CNT_W, 8, width of the instruction count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle load command; ignored unless in IDLE.
- base_addr  input  ADDR_W  byte address of the first word; latched on start.
- count  input  CNT_W  number of instructions to accept; latched on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- funct3  input  3  funct3 field (R/I/S/B).
- funct7  input  7  funct7 field (R only).
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  32  immediate, byte offset or value.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  32  encoded word.
- busy  output  1  high in LOAD and in DRAIN.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error flag.

Behaviour:
- Reset values: in_ready, imem_we, imem_addr, imem_wdata, busy, done and err are all 0. State goes to IDLE.
- States:
  - IDLE: on start, latch base_addr into a write pointer and count into a remaining counter, and clear err. If count==0, go to DRAIN; otherwise go to LOAD.
  - LOAD: in_ready=1. A bundle is accepted when in_valid and in_ready are both high. Each accept decrements remaining. The accept that brings remaining to 0 moves the FSM to DRAIN, and in_ready drops in the following cycle.
  - DRAIN: one cycle to let the last write retire. Assert done for one cycle, then return to IDLE.
- Write latency: a bundle accepted at edge t produces imem_we=1 with imem_addr and imem_wdata registered in cycle t+1. After each write the pointer advances by 4. Throughput is one word per cycle.
- Encoding, bit positions MSB to LSB:
  - R: funct7, rs2, rs1, funct3, rd, 0110011.
  - I: imm[11:0], rs1, funct3, rd, 0010011.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
  - U: imm[31:12], rd, 0110111.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- Unused input fields are ignored.
- Illegal fmt (6 or 7):
  - The handshake completes and the bundle counts toward count.
  - imem_we stays 0 for that slot and the pointer does not advance.
  - err is set.
- B/J with imm[0]=1: imm[0] is dropped, the word is written normally, and err is set.
- err stays set until the next accepted start or until rst.
- start while busy is ignored: no relatch, and err is not cleared.
- Pointer wrap: base_addr=2^ADDR_W-4 followed by a second word writes that second word at address 0.
- Reset mid-load: the next edge forces IDLE with imem_we=0 and done=0. Words already written are not rolled back.

Test Plan:
- start, base=0x100, count=1; I: funct3=0, rd=1, rs1=0, imm=5 → in cycle t+1: imem_we=1, addr=0x100, wdata=0x00500093; done pulses the next cycle.
- count=4, bundles sent back-to-back with in_valid held high → four consecutive writes:
  - R add x3,x1,x2 → 0x002081B3 at addr 0x000.
  - S sw x2,8(x1) → 0x0020A423 at addr 0x004.
  - U lui x5,0x12345000 → 0x123452B7 at addr 0x008.
  - J jal x1,8 → 0x008000EF at addr 0x00C.
  - in_ready=0 after the fourth accept; done pulses once; err=0.
- B beq x1,x2,imm=-4 → 0xFE208EE3. Same with imm=-3 → 0xFE208EE3 written and err=1. A subsequent start clears err.
- count=3, middle bundle fmt=7 → writes only at base and base+4, no write in the middle slot; done pulses after the third accept; err=1.
- base_addr=0x3FC, count=2 → writes at 0x3FC then 0x000. start issued mid-load is ignored. count=0 → done pulses with no writes.
- rst asserted during LOAD after 2 of 5 writes → imem_we=0, in_ready=0, busy=0 from the next edge. A fresh start works normally.

Source files
------------

// File: rtl/instr_encode_loader_if.sv
// ============================================================================
// Module      : instr_encode_loader_if
// Description : Command, field-bundle handshake and imem write bus for the
//               RV32I encoder/loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instr_encode_loader_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, count, in_valid, fmt, funct3, funct7,
               rd, rs1, rs2, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );

    modport slave (
        input  start, base_addr, count, in_valid, fmt, funct3, funct7,
               rd, rs1, rs2, imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/instr_encode_loader.sv
// ============================================================================
// Module      : instr_encode_loader
// Description : Packs decoded RV32I fields into instruction words and writes
//               them sequentially into instruction memory.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_encode_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    instr_encode_loader_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [2:0] c_fmt_r = 3'd0;
    localparam logic [2:0] c_fmt_i = 3'd1;
    localparam logic [2:0] c_fmt_s = 3'd2;
    localparam logic [2:0] c_fmt_b = 3'd3;
    localparam logic [2:0] c_fmt_u = 3'd4;
    localparam logic [2:0] c_fmt_j = 3'd5;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;

    logic              w_start;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_legal;
    logic              w_misalign;
    logic [31:0]       w_word;

    assign w_start    = bus.start && (r_state == c_st_idle);
    assign w_in_ready = (r_state == c_st_load);
    assign w_accept   = w_in_ready && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_nxt = (bus.count == '0) ? c_st_drain : c_st_load;
                end
            end
            c_st_load: begin
                if (w_accept && (r_remaining == CNT_W'(1))) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Branch/jump offsets are halfword aligned, so imm[0] has no slot in the word.
    always_comb begin
        w_word     = '0;
        w_legal    = 1'b1;
        w_misalign = 1'b0;
        case (bus.fmt)
            c_fmt_r: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
            c_fmt_i: w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
            c_fmt_s: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
            c_fmt_b: begin
                w_word     = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                              bus.imm[4:1], bus.imm[11], 7'b1100011};
                w_misalign = bus.imm[0];
            end
            c_fmt_u: w_word = {bus.imm[31:12], bus.rd, 7'b0110111};
            c_fmt_j: begin
                w_word     = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                              bus.rd, 7'b1101111};
                w_misalign = bus.imm[0];
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= (r_state == c_st_drain);
            if (w_start) begin
                r_ptr       <= bus.base_addr;
                r_remaining <= bus.count;
                r_err       <= 1'b0;
            end
            if (w_accept) begin
                r_remaining <= r_remaining - CNT_W'(1);
                // Illegal slots consume a count but leave the pointer in place.
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_ptr   <= r_ptr + ADDR_W'(4);
                end
                if (!w_legal || w_misalign) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.busy       = (r_state == c_st_load) || (r_state == c_st_drain);
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
// ============================================================================
// Module      : tb_instr_encode_loader
// Description : Self-checking bench for instr_encode_loader with an
//               arithmetic RV32I encoding model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encode_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          gap;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encode_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    instr_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bundle_t     stim[$];
    logic [9:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    logic        model_err;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] ref_encode(input bundle_t b);
        logic [31:0] i;
        logic [31:0] r1, r2, d, f3;
        i  = b.imm;
        r1 = 32'(b.rs1) << 15;
        r2 = 32'(b.rs2) << 20;
        d  = 32'(b.rd) << 7;
        f3 = 32'(b.f3) << 12;
        case (b.fmt)
            3'd0: return (32'(b.f7) << 25) | r2 | r1 | f3 | d | 32'h33;
            3'd1: return ((i & 32'hFFF) << 20) | r1 | f3 | d | 32'h13;
            3'd2: return (((i >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((i & 32'h1F) << 7) | 32'h23;
            3'd3: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | r2 | r1 | f3
                         | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
            3'd4: return (i & 32'hFFFFF000) | d | 32'h37;
            3'd5: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                         | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | d | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bundle_t mk(input int fmt, input int f3, input int f7, input int rd,
                                   input int rs1, input int rs2, input logic [31:0] imm);
        bundle_t b;
        b.fmt = 3'(fmt); b.f3 = 3'(f3); b.f7 = 7'(f7);
        b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
        b.imm = imm; b.gap = 0;
        return b;
    endfunction

    function automatic bundle_t mk_rand();
        bundle_t b;
        b.fmt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
        b.f3  = 3'($urandom);
        b.f7  = 7'($urandom);
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        b.imm = $urandom;
        b.gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input bundle_t b);
        bus.fmt    = b.fmt;
        bus.funct3 = b.f3;
        bus.funct7 = b.f7;
        bus.rd     = b.rd;
        bus.rs1    = b.rs1;
        bus.rs2    = b.rs2;
        bus.imm    = b.imm;
    endtask

    // Runs one complete load of stim[0..cnt-1]; poke pulses a second start mid-load.
    task automatic run_load(input logic [9:0] base, input logic [7:0] cnt, input bit poke);
        logic [9:0]  ptr;
        bundle_t     b;
        logic        legal;
        logic [31:0] exp_w;
        ptr = base;
        obs_addr.delete();
        obs_data.delete();
        bus.start = 1'b1; bus.base_addr = base; bus.count = cnt;
        step();
        bus.start = 1'b0;
        model_err = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL start_state busy=%b err=%b expected busy=1 err=0", bus.busy, bus.err);
        end
        for (int i = 0; i < int'(cnt); i++) begin
            b = stim[i];
            for (int g = 0; g < b.gap; g++) begin
                bus.in_valid = 1'b0;
                step();
                checks++;
                if (bus.imem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_write slot=%0d we=%b expected 0", i, bus.imem_we);
                end
            end
            drive_fields(b);
            bus.in_valid = 1'b1;
            if (poke && i == 0) begin
                bus.start = 1'b1; bus.base_addr = 10'h200; bus.count = 8'd7;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL in_ready slot=%0d got=%b expected 1", i, bus.in_ready);
            end
            step();
            bus.start = 1'b0;
            legal = (b.fmt < 3'd6);
            exp_w = ref_encode(b);
            if (!legal || ((b.fmt == 3'd3 || b.fmt == 3'd5) && b.imm[0])) model_err = 1'b1;
            checks++;
            if (legal) begin
                if (bus.imem_we !== 1'b1 || bus.imem_addr !== ptr || bus.imem_wdata !== exp_w) begin
                    failures++;
                    $display("FAIL write slot=%0d we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                             i, bus.imem_we, bus.imem_addr, bus.imem_wdata, ptr, exp_w);
                end
                ptr = ptr + 10'd4;
            end else if (bus.imem_we !== 1'b0) begin
                failures++;
                $display("FAIL illegal_write slot=%0d we=%b expected 0", i, bus.imem_we);
            end
            if (bus.imem_we === 1'b1) begin
                obs_addr.push_back(bus.imem_addr);
                obs_data.push_back(bus.imem_wdata);
            end
            checks++;
            if (bus.err !== model_err) begin
                failures++;
                $display("FAIL err slot=%0d got=%b expected %b", i, bus.err, model_err);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL drain_state ready=%b busy=%b done=%b expected 0 1 0",
                     bus.in_ready, bus.busy, bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.imem_we !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse done=%b busy=%b we=%b expected 1 0 0",
                     bus.done, bus.busy, bus.imem_we);
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_width done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        checks++;
        if ({bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b expected 00000",
                     {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.imem_addr !== 10'h0 || bus.imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h data=%h expected 0 0", bus.imem_addr, bus.imem_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        stim.delete();
        stim.push_back(mk(1, 0, 0, 1, 0, 0, 32'd5));
        run_load(10'h100, 8'd1, 1'b0);
        checks++;
        if (obs_data.size() != 1 || obs_addr[0] !== 10'h100 || obs_data[0] !== 32'h00500093) begin
            failures++;
            $display("FAIL single_addi writes=%0d expected 1 at 100 data 00500093", obs_data.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] golden [4] = '{32'h002081B3, 32'h0020A423, 32'h123452B7, 32'h008000EF};
        stim.delete();
        stim.push_back(mk(0, 0, 0, 3, 1, 2, 32'd0));
        stim.push_back(mk(2, 2, 0, 0, 1, 2, 32'd8));
        stim.push_back(mk(4, 0, 0, 5, 0, 0, 32'h12345000));
        stim.push_back(mk(5, 0, 0, 1, 0, 0, 32'd8));
        run_load(10'h000, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_data.size() != 4 || obs_data[i] !== golden[i] || obs_addr[i] !== 10'(i * 4)) begin
                failures++;
                $display("FAIL b2b_word idx=%0d got=%h expected %h at %h", i,
                         (obs_data.size() > i) ? obs_data[i] : 32'hX, golden[i], 10'(i * 4));
            end
        end
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_err got=%b expected 0", bus.err);
        end
    endtask

    task automatic test_branch();
        stim.delete();
        stim.push_back(mk(3, 0, 0, 0, 1, 2, 32'hFFFFFFFC));
        run_load(10'h020, 8'd1, 1'b0);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'hFE208EE3 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL beq_m4 err=%b expected word FE208EE3 err=0", bus.err);
        end
        stim.delete();
        stim.push_back(mk(3, 0, 0, 0, 1, 2, 32'hFFFFFFFD));
        run_load(10'h020, 8'd1, 1'b0);
        checks++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'hFE208EE3 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL beq_m3 err=%b expected word FE208EE3 err=1", bus.err);
        end
    endtask

    task automatic test_illegal();
        stim.delete();
        stim.push_back(mk(1, 0, 0, 2, 3, 0, 32'd1));
        stim.push_back(mk(7, 0, 0, 2, 3, 0, 32'd2));
        stim.push_back(mk(1, 0, 0, 4, 5, 0, 32'd3));
        run_load(10'h080, 8'd3, 1'b0);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 10'h080 || obs_addr[1] !== 10'h084 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_slot writes=%0d err=%b expected 2 writes at 080/084 err=1",
                     obs_addr.size(), bus.err);
        end
    endtask

    task automatic test_wrap_and_zero();
        stim.delete();
        stim.push_back(mk(4, 0, 0, 7, 0, 0, 32'hABCDE000));
        stim.push_back(mk(1, 3, 0, 8, 9, 0, 32'h00000FFF));
        run_load(10'h3FC, 8'd2, 1'b1);
        checks++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 10'h3FC || obs_addr[1] !== 10'h000) begin
            failures++;
            $display("FAIL wrap writes=%0d expected 2 at 3FC then 000", obs_addr.size());
        end
        stim.delete();
        run_load(10'h010, 8'd0, 1'b0);
        checks++;
        if (obs_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_count writes=%0d expected 0", obs_addr.size());
        end
    endtask

    task automatic test_reset_midload();
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(mk(1, 0, 0, i + 1, 0, 0, 32'(i)));
        bus.start = 1'b1; bus.base_addr = 10'h040; bus.count = 8'd5;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_fields(stim[i]);
            bus.in_valid = 1'b1;
            step();
            checks++;
            if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'(10'h040 + 4 * i)
                || bus.imem_wdata !== ref_encode(stim[i])) begin
                failures++;
                $display("FAIL pre_reset_write idx=%0d we=%b addr=%h data=%h", i,
                         bus.imem_we, bus.imem_addr, bus.imem_wdata);
            end
        end
        drive_fields(stim[2]);
        rst = 1'b1;
        step();
        checks++;
        if ({bus.imem_we, bus.in_ready, bus.busy, bus.done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_midload we/ready/busy/done=%b expected 0000",
                     {bus.imem_we, bus.in_ready, bus.busy, bus.done});
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle ready=%b busy=%b expected 0 0", bus.in_ready, bus.busy);
        end
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(mk_rand());
        run_load(10'h140, 8'd3, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(1, 12));
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(mk_rand());
            run_load(10'($urandom) & 10'h3FC, 8'(n), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.in_valid = 1'b0;
        bus.fmt = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_wrap_and_zero();
        test_reset_midload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
